alu_arbiter: RTL and testbench

- Shares one combinational 8-bit ALU between NUM_REQ requesters.
- Each requester presents operands a, b and a 4-bit op select through a valid/ready handshake.
- The arbiter grants requesters round-robin and drives the shared ALU from registered operands.
- It captures the result and returns it through a single response channel tagged with the requester ID.

---
 rtl/alu_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin arbiter that shares one external 8-bit ALU among
//               NUM_REQ requesters and returns ID-tagged results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  input  logic [NUM_REQ*8-1:0]   req_a_i,
  input  logic [NUM_REQ*8-1:0]   req_b_i,
  input  logic [NUM_REQ*4-1:0]   req_sel_i,
  output logic                   resp_valid_o,
  input  logic                   resp_ready_i,
  output logic [7:0]             resp_data_o,
  output logic [ID_W-1:0]        resp_id_o,
  output logic                   resp_err_o,
  output logic [7:0]             alu_a_o,
  output logic [7:0]             alu_b_o,
  output logic [3:0]             alu_sel_o,
  input  logic [7:0]             alu_out_i,
  output logic                   busy_o
);

  localparam logic [3:0] C_SEL_DIV = 4'b0011;
  localparam int         C_PAD    = 1 << ID_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic [7:0]        op_a_q, op_a_d;
  logic [7:0]        op_b_q, op_b_d;
  logic [3:0]        op_sel_q, op_sel_d;
  logic              resp_valid_q, resp_valid_d;
  logic [7:0]        resp_data_q, resp_data_d;
  logic [ID_W-1:0]   resp_id_q, resp_id_d;
  logic              resp_err_q, resp_err_d;

  logic [C_PAD-1:0]  w_valid_pad;
  logic              w_gnt_found;
  logic [ID_W-1:0]   w_gnt_idx;
  logic [ID_W:0]     w_cand;
  logic [7:0]        w_pick_a;
  logic [7:0]        w_pick_b;
  logic [3:0]        w_pick_sel;
  logic              w_accept;
  logic              w_resp_fire;
  logic              w_div_zero;

  // Search upward from the requester after the last winner, wrapping at NUM_REQ.
  always_comb begin
    w_valid_pad                = '0;
    w_valid_pad[NUM_REQ-1:0]   = req_valid_i;
    w_gnt_found                = 1'b0;
    w_gnt_idx                  = '0;
    w_cand                     = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_cand = {1'b0, last_grant_q} + (ID_W+1)'(k);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      end
      if (!w_gnt_found && w_valid_pad[w_cand[ID_W-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_idx   = w_cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    w_pick_a   = '0;
    w_pick_b   = '0;
    w_pick_sel = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt_idx == ID_W'(k)) begin
        w_pick_a   = req_a_i[8*k +: 8];
        w_pick_b   = req_b_i[8*k +: 8];
        w_pick_sel = req_sel_i[4*k +: 4];
      end
    end
  end

  assign w_accept    = (state_q == ST_IDLE) && w_gnt_found;
  assign w_resp_fire = (state_q == ST_RESP) && resp_valid_q && resp_ready_i;
  assign w_div_zero  = (op_sel_q == C_SEL_DIV) && (op_b_q == 8'h00);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and grant strobe
  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    case (state_q)
      ST_IDLE: begin
        if (w_gnt_found) begin
          req_ready_o = NUM_REQ'(1) << w_gnt_idx;
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (w_resp_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values; everything holds unless an event updates it.
  always_comb begin
    last_grant_d = last_grant_q;
    gnt_id_d     = gnt_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_sel_d     = op_sel_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_id_d    = resp_id_q;
    resp_err_d   = resp_err_q;

    if (w_accept) begin
      op_a_d       = w_pick_a;
      op_b_d       = w_pick_b;
      op_sel_d     = w_pick_sel;
      gnt_id_d     = w_gnt_idx;
      last_grant_d = w_gnt_idx;
    end

    if (state_q == ST_EXEC) begin
      resp_valid_d = 1'b1;
      resp_id_d    = gnt_id_q;
      resp_err_d   = w_div_zero;
      resp_data_d  = w_div_zero ? 8'hFF : alu_out_i;
    end else if (w_resp_fire) begin
      resp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= ID_W'(NUM_REQ - 1);
      gnt_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_sel_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_id_q    <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      gnt_id_q     <= gnt_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_sel_q     <= op_sel_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_id_q    <= resp_id_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Operand registers feed the shared ALU directly, so it sees them for all of EXEC.
  assign alu_a_o      = op_a_q;
  assign alu_b_o      = op_b_q;
  assign alu_sel_o    = op_sel_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_id_o    = resp_id_q;
  assign resp_err_o   = resp_err_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with an ALU model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*8-1:0] req_a;
  logic [NUM_REQ*8-1:0] req_b;
  logic [NUM_REQ*4-1:0] req_sel;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [7:0]           resp_data;
  logic [ID_W-1:0]      resp_id;
  logic                 resp_err;
  logic [7:0]           alu_a;
  logic [7:0]           alu_b;
  logic [3:0]           alu_sel;
  logic [7:0]           alu_out;
  logic                 busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_a_i     (req_a),
    .req_b_i     (req_b),
    .req_sel_i   (req_sel),
    .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready),
    .resp_data_o (resp_data),
    .resp_id_o   (resp_id),
    .resp_err_o  (resp_err),
    .alu_a_o     (alu_a),
    .alu_b_o     (alu_b),
    .alu_sel_o   (alu_sel),
    .alu_out_i   (alu_out),
    .busy_o      (busy)
  );

  // External ALU; divide by zero returns 0 so the arbiter's 8'hFF forcing is visible.
  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] sel);
    case (sel)
      4'b0000: return a + b;
      4'b0001: return a - b;
      4'b0011: return (b == 8'h00) ? 8'h00 : a / b;
      4'b0110: return {a[6:0], a[7]};
      4'b1010: return a | b;
      4'b1110: return (a > b) ? 8'd1 : 8'd0;
      default: return 8'h00;
    endcase
  endfunction

  assign alu_out = alu_model(alu_a, alu_b, alu_sel);

  task automatic set_req(input int id, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] sel);
    req_a[8*id +: 8]   = a;
    req_b[8*id +: 8]   = b;
    req_sel[4*id +: 4] = sel;
  endtask

  task automatic apply_reset();
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    req_sel    = '0;
    resp_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_data !== 8'h00) begin errors++; $display("FAIL reset_resp_data: got %h want 00", resp_data); end
    checks++; if (resp_id !== 2'd0) begin errors++; $display("FAIL reset_resp_id: got %0d want 0", resp_id); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_resp_err: got %b want 0", resp_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if ({alu_a, alu_b, alu_sel} !== 20'h0) begin errors++; $display("FAIL reset_alu_regs: got %h want 0", {alu_a, alu_b, alu_sel}); end
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
  endtask

  // Single isolated request on an idle arbiter; entered and left at a falling edge.
  task automatic test_op(input string name, input int id, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] sel,
                         input logic [7:0] exp_d, input logic exp_e);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    set_req(id, a, b, sel);
    req_valid[id] = 1'b1;
    resp_ready    = 1'b1;
    #1;
    checks++; if (req_ready !== onehot) begin errors++; $display("FAIL %s_grant: got %b want %b", name, req_ready, onehot); end
    @(negedge clk);
    req_valid[id] = 1'b0;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL %s_exec_ready: got %b want 0000", name, req_ready); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL %s_exec_busy: got %b want 1", name, busy); end
    checks++; if ({alu_a, alu_b, alu_sel} !== {a, b, sel}) begin errors++; $display("FAIL %s_alu_in: got %h want %h", name, {alu_a, alu_b, alu_sel}, {a, b, sel}); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL %s_early_valid: got %b want 0", name, resp_valid); end
    @(negedge clk);
    checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL %s_resp_valid: got %b want 1", name, resp_valid); end
    checks++; if (resp_data !== exp_d) begin errors++; $display("FAIL %s_resp_data: got %h want %h", name, resp_data, exp_d); end
    checks++; if (resp_id !== 2'(id)) begin errors++; $display("FAIL %s_resp_id: got %0d want %0d", name, resp_id, id); end
    checks++; if (resp_err !== exp_e) begin errors++; $display("FAIL %s_resp_err: got %b want %b", name, resp_err, exp_e); end
    @(negedge clk);
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL %s_idle: got valid/busy %b want 00", name, {resp_valid, busy}); end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_d [4];
    logic [3:0] onehot;
    int e;
    exp_d = '{8'd99, 8'd108, 8'd117, 8'd126};
    apply_reset();
    set_req(0, 8'd100, 8'd1, 4'b0001);
    set_req(1, 8'd110, 8'd2, 4'b0001);
    set_req(2, 8'd120, 8'd3, 4'b0001);
    set_req(3, 8'd130, 8'd4, 4'b0001);
    req_valid  = 4'b1111;
    resp_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      e      = g % 4;
      onehot = 4'b0001 << e;
      #1;
      checks++; if (req_ready !== onehot) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, onehot); end
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_exec_ready%0d: got %b want 0000", g, req_ready); end
      @(negedge clk);
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rr_resp_ready%0d: got %b want 0000", g, req_ready); end
      checks++; if ({resp_valid, resp_id} !== {1'b1, 2'(e)}) begin errors++; $display("FAIL rr_resp_id%0d: got valid/id %b/%0d want 1/%0d", g, resp_valid, resp_id, e); end
      checks++; if (resp_data !== exp_d[e]) begin errors++; $display("FAIL rr_resp_data%0d: got %0d want %0d", g, resp_data, exp_d[e]); end
      @(negedge clk);
    end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    set_req(1, 8'hF0, 8'h0F, 4'b1010);
    req_valid[1] = 1'b1;
    resp_ready   = 1'b0;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid[1] = 1'b0;
    set_req(3, 8'd1, 8'd2, 4'b0000);
    req_valid[3] = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      checks++; if ({resp_valid, resp_data, resp_id, resp_err} !== {1'b1, 8'hFF, 2'd1, 1'b0}) begin errors++; $display("FAIL bp_hold%0d: got v/d/id/e %b/%h/%0d/%b want 1/ff/1/0", c, resp_valid, resp_data, resp_id, resp_err); end
      checks++; if ({busy, req_ready} !== 5'b10000) begin errors++; $display("FAIL bp_stall%0d: got busy/ready %b/%b want 1/0000", c, busy, req_ready); end
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({busy, resp_valid} !== 2'b00) begin errors++; $display("FAIL bp_release: got busy/valid %b want 00", {busy, resp_valid}); end
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_next_grant: got %b want 1000", req_ready); end
    @(negedge clk);
    req_valid[3] = 1'b0;
    @(negedge clk);
    checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd3, 8'd3}) begin errors++; $display("FAIL bp_follow: got v/id/d %b/%0d/%0d want 1/3/3", resp_valid, resp_id, resp_data); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_op();
    set_req(1, 8'd7, 8'd1, 4'b0000);
    req_valid[1] = 1'b1;
    resp_ready   = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_exec_busy: got %b want 1", busy); end
    req_valid[1] = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL mid_abort: got valid/busy %b want 00", {resp_valid, busy}); end
    checks++; if (alu_a !== 8'h00) begin errors++; $display("FAIL mid_alu_clear: got %h want 00", alu_a); end
    @(negedge clk);
    checks++; if ({resp_valid, busy} !== 2'b00) begin errors++; $display("FAIL mid_no_reserve: got valid/busy %b want 00", {resp_valid, busy}); end
    set_req(0, 8'd1, 8'd1, 4'b0000);
    req_valid = 4'b0011;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b want 0001", req_ready); end
    @(negedge clk);
    @(negedge clk);
    checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd0, 8'd2}) begin errors++; $display("FAIL mid_resp0: got v/id/d %b/%0d/%0d want 1/0/2", resp_valid, resp_id, resp_data); end
    @(negedge clk);
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_second_grant: got %b want 0010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    checks++; if ({resp_valid, resp_id, resp_data} !== {1'b1, 2'd1, 8'd8}) begin errors++; $display("FAIL mid_resp1: got v/id/d %b/%0d/%0d want 1/1/8", resp_valid, resp_id, resp_data); end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_op("single", 2, 8'd20, 8'd22, 4'b0000, 8'd42, 1'b0);
    test_round_robin();
    test_backpressure();
    test_op("div0", 0, 8'd9, 8'd0, 4'b0011, 8'hFF, 1'b1);
    test_op("div", 0, 8'd9, 8'd3, 4'b0011, 8'd3, 1'b0);
    test_op("cmp", 2, 8'd5, 8'd3, 4'b1110, 8'd1, 1'b0);
    test_op("rot", 3, 8'h81, 8'h00, 4'b0110, 8'h03, 1'b0);
    test_reset_mid_op();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
